// File: rtl/cache_mem_responder.sv
// ---------------------------------------------------------------------------
// cache_mem_responder
//
// Word-organised memory model that answers a cache's refill and write-back
// traffic. It handles one transaction at a time: a read (single word or a
// four-word line burst) or a write (byte-masked word merge or a four-word
// line store). Reads return data after a fixed latency, one beat per cycle.
//
// Parameters
//   ADDR_W  log2 of memory depth in 32-bit words (word index = addr[ADDR_W+1:2])
//   RD_LAT  cycles from read acceptance to first ret_valid (1..15)
//
// Ports
//   clk        clock, rising edge
//   resetn     synchronous active-low reset
//   rd_req     read request            rd_type   000 byte, 001 half, 010 word, 100 line
//   rd_addr    read byte address       rd_rdy    read accepted when rd_req & rd_rdy
//   ret_valid  return beat valid       ret_last  bit0 marks final beat, bit1 always 0
//   ret_data   return beat data (zero when ret_valid is low)
//   wr_req     write request           wr_type   encoding as rd_type
//   wr_addr    write byte address      wr_wstrb  byte enables for non-line writes
//   wr_data    line data, word 0 in [31:0]
//   wr_rdy     write accepted when wr_req & wr_rdy
//
// Optional feature
//   CACHE_MEM_RESPONDER_BP_EN  when defined, an 8-bit LFSR injects read
//   back-pressure: bubbles between burst beats and random rd_rdy stalls.
// ---------------------------------------------------------------------------
module cache_mem_responder #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic [1:0]   ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy
);

    localparam logic [2:0] TYPE_LINE = 3'b100;
    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LOAD = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_LINE
    } state_t;

    state_t              state;
    logic [31:0]         mem [DEPTH];

    logic [ADDR_W-1:0]   rd_base;
    logic                rd_is_line;
    logic [3:0]          wait_cnt;
    logic [1:0]          beat_cnt;

    logic [ADDR_W-1:0]   wr_base;
    logic [1:0]          wr_cnt;
    logic [127:0]        line_buf;

    logic [ADDR_W-1:0]   rd_word;
    logic [ADDR_W-1:0]   wr_word;
    logic [ADDR_W-1:0]   beat_addr;
    logic                rd_accept;
    logic                wr_accept;
    logic                rd_is_line_in;
    logic                wr_is_line_in;
    logic                beat_en;
    logic                beat_final;
    logic                bubble;
    logic                stall;
    logic                unused_addr_bits;

    // Address bits above the memory depth alias onto the same words, and the
    // byte offset never selects a lane, so those bits are deliberately dropped.
    assign rd_word          = rd_addr[ADDR_W+1:2];
    assign wr_word          = wr_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{rd_addr[31:ADDR_W+2], rd_addr[1:0],
                                wr_addr[31:ADDR_W+2], wr_addr[1:0]};

    // Every code other than 100 behaves as a single word access.
    assign rd_is_line_in = (rd_type == TYPE_LINE);
    assign wr_is_line_in = (wr_type == TYPE_LINE);

`ifdef CACHE_MEM_RESPONDER_BP_EN
    logic [7:0] lfsr;

    // Free-running back-pressure source; taps 8,6,5,4 give a maximal-length
    // sequence, so it never locks up from the nonzero seed.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign bubble = lfsr[0];
    assign stall  = lfsr[1];
`else
    assign bubble = 1'b0;
    assign stall  = 1'b0;
`endif

    // Handshakes are gated by resetn so both readies read low while reset is
    // held. A pending write blocks reads, which gives writes priority.
    assign wr_rdy    = resetn & (state == IDLE);
    assign rd_rdy    = resetn & (state == IDLE) & ~wr_req & ~stall;
    assign wr_accept = wr_req & wr_rdy;
    assign rd_accept = rd_req & rd_rdy;

    // Line bases have their low two bits cleared, so OR-ing in the beat
    // number walks the four words without any carry.
    assign beat_en    = (state == RD_BURST) & ~bubble;
    assign beat_final = ~rd_is_line | (beat_cnt == 2'd3);
    assign beat_addr  = rd_base | ADDR_W'(beat_cnt);

    // Memory array: deliberately never reset so contents survive resetn.
    // Masked word writes land in their acceptance cycle; line writes drain
    // one word per cycle from the captured line buffer.
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (state == WR_LINE) begin
                mem[wr_base | ADDR_W'(wr_cnt)] <= line_buf[31:0];
            end else if (wr_accept && !wr_is_line_in) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_wstrb[b]) begin
                        mem[wr_word][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Transaction sequencer with registered return outputs. The return
    // signals default to zero each cycle and are only raised for a beat.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            ret_valid  <= 1'b0;
            ret_last   <= 2'b00;
            ret_data   <= '0;
            rd_base    <= '0;
            rd_is_line <= 1'b0;
            wait_cnt   <= '0;
            beat_cnt   <= '0;
            wr_base    <= '0;
            wr_cnt     <= '0;
            line_buf   <= '0;
        end else begin
            ret_valid <= 1'b0;
            ret_last  <= 2'b00;
            ret_data  <= '0;

            case (state)
                IDLE: begin
                    if (wr_accept) begin
                        if (wr_is_line_in) begin
                            state    <= WR_LINE;
                            wr_base  <= {wr_word[ADDR_W-1:2], 2'b00};
                            line_buf <= wr_data;
                            wr_cnt   <= '0;
                        end
                    end else if (rd_accept) begin
                        rd_is_line <= rd_is_line_in;
                        rd_base    <= rd_is_line_in ? {rd_word[ADDR_W-1:2], 2'b00} : rd_word;
                        beat_cnt   <= '0;
                        if (RD_LAT == 1) begin
                            state <= RD_BURST;
                        end else begin
                            state    <= RD_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end

                // The burst state itself costs one cycle before the first
                // beat, so the wait phase covers the remaining RD_LAT-1.
                RD_WAIT: begin
                    if (wait_cnt <= 4'd1) begin
                        state    <= RD_BURST;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                RD_BURST: begin
                    if (beat_en) begin
                        ret_valid <= 1'b1;
                        ret_data  <= mem[beat_addr];
                        ret_last  <= {1'b0, beat_final};
                        beat_cnt  <= beat_cnt + 2'd1;
                        if (beat_final) begin
                            state <= IDLE;
                        end
                    end
                end

                WR_LINE: begin
                    line_buf <= line_buf >> 32;
                    wr_cnt   <= wr_cnt + 2'd1;
                    if (wr_cnt == 2'd3) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
